// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle for multicycle_ctrl.
// PERF_CNT_EN adds the retired/cycles counter outputs.
interface multicycle_ctrl_if;
   logic        start;
   logic [31:0] instr;
   logic [2:0]  flags;
   logic        imem_req;
   logic        imem_ack;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic        ir_en;
   logic        pc_en;
   logic        reg_we;
   logic        flag_we;
   logic        alu_src;
   logic        wb_sel;
   logic [1:0]  pc_src;
   logic [1:0]  imm_sel;
   logic        busy;
   logic        halted;
   logic        err;
`ifdef PERF_CNT_EN
   logic [31:0] retired;
   logic [31:0] cycles;

   modport master (
      input  start, instr, flags, imem_ack, dmem_ack,
      output imem_req, dmem_req, dmem_we, ir_en, pc_en, reg_we, flag_we,
             alu_src, wb_sel, pc_src, imm_sel, busy, halted, err,
             retired, cycles
   );
   modport slave (
      output start, instr, flags, imem_ack, dmem_ack,
      input  imem_req, dmem_req, dmem_we, ir_en, pc_en, reg_we, flag_we,
             alu_src, wb_sel, pc_src, imm_sel, busy, halted, err,
             retired, cycles
   );
`else
   modport master (
      input  start, instr, flags, imem_ack, dmem_ack,
      output imem_req, dmem_req, dmem_we, ir_en, pc_en, reg_we, flag_we,
             alu_src, wb_sel, pc_src, imm_sel, busy, halted, err
   );
   modport slave (
      output start, instr, flags, imem_ack, dmem_ack,
      input  imem_req, dmem_req, dmem_we, ir_en, pc_en, reg_we, flag_we,
             alu_src, wb_sel, pc_src, imm_sel, busy, halted, err
   );
`endif
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/wb with ack timeouts.
// Define PERF_CNT_EN to add the retired-instruction and busy-cycle counters.
module multicycle_ctrl #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);
   // state  | meaning
   // IDLE   | waiting for start
   // FETCH  | imem_req held until imem_ack or timeout
   // DECODE | instruction register valid, imm_sel driven
   // EXEC   | ALU op / branch resolve / route to MEM or HALT
   // MEM    | dmem_req held until dmem_ack or timeout
   // WB     | register write plus sequential pc update
   // HALT   | absorbing until reset
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [2:0] C_RALU  = 3'b000;
   localparam logic [2:0] C_IALU  = 3'b001;
   localparam logic [2:0] C_LOAD  = 3'b010;
   localparam logic [2:0] C_STORE = 3'b011;
   localparam logic [2:0] C_BR    = 3'b100;
   localparam logic [2:0] C_BRC   = 3'b101;
   localparam logic [2:0] C_BRR   = 3'b110;
   localparam logic [7:0] TMR_INIT = 8'(ACK_TIMEOUT - 1);

   state_t     r_state, w_next;
   logic [7:0] r_timer;
   logic       r_err;

   logic [2:0] w_cls, w_cc;
   logic       w_z, w_c, w_s, w_cond;
   logic       w_timeout, w_load_tmr;
   logic       w_imem_req, w_dmem_req, w_dmem_we;
   logic       w_ir_en, w_pc_en, w_reg_we, w_flag_we, w_alu_src, w_wb_sel;
   logic [1:0] w_pc_src, w_imm_sel;
   logic       w_busy;
   logic       w_unused;

   assign w_cls           = bus.instr[31:29];
   assign w_cc            = bus.instr[28:26];
   assign {w_s, w_c, w_z} = bus.flags;
   // operand fields belong to the datapath
   assign w_unused        = ^bus.instr[25:0];

   always_comb begin
      case (w_cc)
         3'b000:  w_cond = w_z;
         3'b001:  w_cond = ~w_z;
         3'b010:  w_cond = w_c;
         3'b011:  w_cond = ~w_c;
         3'b100:  w_cond = w_s;
         default: w_cond = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_imem_req = 1'b0;
      w_dmem_req = 1'b0;
      w_dmem_we  = 1'b0;
      w_ir_en    = 1'b0;
      w_pc_en    = 1'b0;
      w_reg_we   = 1'b0;
      w_flag_we  = 1'b0;
      w_alu_src  = 1'b0;
      w_wb_sel   = 1'b0;
      w_pc_src   = 2'b00;
      w_imm_sel  = 2'b00;
      w_timeout  = 1'b0;

      if (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
         case (w_cls)
            C_IALU, C_LOAD, C_STORE: w_imm_sel = 2'b01;
            C_BR, C_BRC:             w_imm_sel = 2'b10;
            default:                 w_imm_sel = 2'b00;
         endcase
      end

      case (r_state)
         S_IDLE: if (bus.start) w_next = S_FETCH;
         S_FETCH: begin
            w_imem_req = 1'b1;
            // a late ack on the final timer cycle still wins over the timeout
            if (bus.imem_ack) begin
               w_ir_en = 1'b1;
               w_next  = S_DECODE;
            end else if (r_timer == 8'd0) begin
               w_timeout = 1'b1;
               w_next    = S_HALT;
            end
         end
         S_DECODE: w_next = S_EXEC;
         S_EXEC: begin
            case (w_cls)
               C_RALU, C_IALU: begin
                  w_flag_we = 1'b1;
                  w_alu_src = (w_cls == C_IALU);
                  w_next    = S_WB;
               end
               C_LOAD, C_STORE: w_next = S_MEM;
               C_BR: begin
                  w_pc_en  = 1'b1;
                  w_pc_src = 2'b01;
                  w_next   = S_FETCH;
               end
               C_BRC: begin
                  w_pc_en  = 1'b1;
                  w_pc_src = w_cond ? 2'b01 : 2'b00;
                  w_next   = S_FETCH;
               end
               C_BRR: begin
                  w_pc_en  = 1'b1;
                  w_pc_src = 2'b10;
                  w_next   = S_FETCH;
               end
               default: w_next = S_HALT;
            endcase
         end
         S_MEM: begin
            w_dmem_req = 1'b1;
            w_dmem_we  = (w_cls == C_STORE);
            if (bus.dmem_ack) begin
               if (w_cls == C_STORE) begin
                  w_pc_en = 1'b1;
                  w_next  = S_FETCH;
               end else begin
                  w_next  = S_WB;
               end
            end else if (r_timer == 8'd0) begin
               w_timeout = 1'b1;
               w_next    = S_HALT;
            end
         end
         S_WB: begin
            w_reg_we = 1'b1;
            w_pc_en  = 1'b1;
            w_wb_sel = (w_cls == C_LOAD);
            w_next   = S_FETCH;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_load_tmr = ((w_next == S_FETCH) || (w_next == S_MEM)) && (w_next != r_state);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_timer <= 8'd0;
         r_err   <= 1'b0;
      end else begin
         if (w_load_tmr)
            r_timer <= TMR_INIT;
         else if (((r_state == S_FETCH) || (r_state == S_MEM)) && (r_timer != 8'd0))
            r_timer <= r_timer - 8'd1;
         if (w_timeout)
            r_err <= 1'b1;
      end
   end

   assign w_busy = (r_state != S_IDLE) && (r_state != S_HALT);

`ifdef PERF_CNT_EN
   logic [31:0] r_retired;
   logic [31:0] r_cycles;

   // both counters stop on their own in HALT since pc_en and busy are low there
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_retired <= 32'd0;
         r_cycles  <= 32'd0;
      end else begin
         if (w_pc_en) r_retired <= r_retired + 32'd1;
         if (w_busy)  r_cycles  <= r_cycles + 32'd1;
      end
   end

   assign bus.retired = r_retired;
   assign bus.cycles  = r_cycles;
`endif

   assign bus.imem_req = w_imem_req;
   assign bus.dmem_req = w_dmem_req;
   assign bus.dmem_we  = w_dmem_we;
   assign bus.ir_en    = w_ir_en;
   assign bus.pc_en    = w_pc_en;
   assign bus.reg_we   = w_reg_we;
   assign bus.flag_we  = w_flag_we;
   assign bus.alu_src  = w_alu_src;
   assign bus.wb_sel   = w_wb_sel;
   assign bus.pc_src   = w_pc_src;
   assign bus.imm_sel  = w_imm_sel;
   assign bus.busy     = w_busy;
   assign bus.halted   = (r_state == S_HALT);
   assign bus.err      = r_err;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, random
// instruction stream against a transaction-level model, and corner sequences.
module tb_multicycle_ctrl;
   logic clk = 1'b0;
   logic rst;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.ACK_TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int busy_cyc;
      int imem_cyc;
      int dmem_cyc;
      int we_cyc;
      int n_ir;
      int n_flag;
      int n_reg;
      int n_pc;
      int pc_src;
      int imm_dec;
      int imm_end;
      int alu_at_flag;
      int wb_at_reg;
      int halted;
      int collide;
   } obs_t;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  flags;
      int          f_lat;
      int          m_lat;
      int          pc_src;
      int          imm;
      int          busy;
      int          dmem;
      int          alu;
      int          wb;
   } vec_t;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0] outs();
      return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_en, bus.pc_en,
              bus.reg_we, bus.flag_we, bus.alu_src, bus.wb_sel, bus.pc_src,
              bus.imm_sel, bus.busy, bus.halted, bus.err};
   endfunction

   // Expected transaction summary derived from the instruction class rules.
   function automatic obs_t model(input logic [31:0] ins, input logic [2:0] fl,
                                  input int f_lat, input int m_lat);
      obs_t e = '{default: 0};
      int   cls = int'(ins[31:29]);
      int   cc  = int'(ins[28:26]);
      bit   z = fl[0], c = fl[1], s = fl[2];
      bit   taken;
      e.imem_cyc = f_lat;
      e.n_ir     = 1;
      e.busy_cyc = f_lat + 2;
      case (cc)
         0: taken = z;
         1: taken = !z;
         2: taken = c;
         3: taken = !c;
         4: taken = s;
         default: taken = 0;
      endcase
      if (cls == 1 || cls == 2 || cls == 3) e.imm_dec = 1;
      else if (cls == 4 || cls == 5)        e.imm_dec = 2;
      case (cls)
         0, 1: begin
            e.n_flag = 1; e.alu_at_flag = (cls == 1);
            e.n_reg = 1; e.n_pc = 1; e.busy_cyc += 1;
         end
         2: begin
            e.dmem_cyc = m_lat; e.n_reg = 1; e.wb_at_reg = 1;
            e.n_pc = 1; e.busy_cyc += m_lat + 1;
         end
         3: begin
            e.dmem_cyc = m_lat; e.we_cyc = m_lat; e.n_pc = 1; e.busy_cyc += m_lat;
         end
         4: begin e.n_pc = 1; e.pc_src = 1; end
         5: begin e.n_pc = 1; e.pc_src = taken ? 1 : 0; end
         6: begin e.n_pc = 1; e.pc_src = 2; end
         default: e.halted = 1;
      endcase
      e.imm_end = (e.n_pc != 0) ? e.imm_dec : 0;
      return e;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b0;
      bus.start    = 1'b0;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      bus.instr    = 32'd0;
      bus.flags    = 3'd0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
   endtask

   // Acts as instruction/data memory and records one instruction's activity,
   // ending on the pc_en pulse or on entry to HALT.
   task automatic run_instr(input logic [31:0] ins, input logic [2:0] fl,
                            input int f_lat, input int m_lat, output obs_t o);
      int fcnt = 0, mcnt = 0, nb;
      bit done = 0, dec_next = 0;
      o = '{default: 0};
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge clk);
         bus.start    = 1'b0;
         bus.imem_ack = bus.imem_req && (fcnt + 1 >= f_lat);
         if (bus.imem_ack) begin
            bus.instr = ins;
            bus.flags = fl;
         end
         bus.dmem_ack = bus.dmem_req && (mcnt + 1 >= m_lat);
         #1;
         if (bus.busy) o.busy_cyc++;
         if (bus.imem_req) begin o.imem_cyc++; fcnt++; end
         if (bus.dmem_req) begin
            o.dmem_cyc++; mcnt++;
            if (bus.dmem_we) o.we_cyc++;
         end
         if (dec_next) begin o.imm_dec = int'(bus.imm_sel); dec_next = 0; end
         if (bus.ir_en) begin o.n_ir++; dec_next = 1; end
         if (bus.flag_we) begin o.n_flag++; o.alu_at_flag = int'(bus.alu_src); end
         if (bus.reg_we) begin o.n_reg++; o.wb_at_reg = int'(bus.wb_sel); end
         nb = int'(bus.pc_en) + int'(bus.ir_en) + int'(bus.reg_we) + int'(bus.flag_we);
         if (nb > 1 && !(nb == 2 && bus.reg_we && bus.pc_en)) o.collide++;
         if (bus.pc_en) begin
            o.n_pc++; o.pc_src = int'(bus.pc_src); o.imm_end = int'(bus.imm_sel);
            done = 1;
         end
         if (bus.halted) begin o.halted = 1; done = 1; end
      end
      if (!done) chk("run_instr_bound", 0, 1);
   endtask

   task automatic cmp_obs(input string t, input obs_t a, input obs_t e);
      chk({t, ".busy"},   a.busy_cyc,    e.busy_cyc);
      chk({t, ".imem"},   a.imem_cyc,    e.imem_cyc);
      chk({t, ".dmem"},   a.dmem_cyc,    e.dmem_cyc);
      chk({t, ".dwe"},    a.we_cyc,      e.we_cyc);
      chk({t, ".ir_en"},  a.n_ir,        e.n_ir);
      chk({t, ".flag"},   a.n_flag,      e.n_flag);
      chk({t, ".reg_we"}, a.n_reg,       e.n_reg);
      chk({t, ".pc_en"},  a.n_pc,        e.n_pc);
      chk({t, ".pc_src"}, a.pc_src,      e.pc_src);
      chk({t, ".imm_d"},  a.imm_dec,     e.imm_dec);
      chk({t, ".imm_e"},  a.imm_end,     e.imm_end);
      chk({t, ".alu"},    a.alu_at_flag, e.alu_at_flag);
      chk({t, ".wb"},     a.wb_at_reg,   e.wb_at_reg);
      chk({t, ".halt"},   a.halted,      e.halted);
      chk({t, ".excl"},   a.collide,     e.collide);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[14];
      obs_t        o, e;
      logic [31:0] ins;
      logic [2:0]  fl;
      int          fa, ma, cnt, bad;

      rst = 1'b0;
      bus.start = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
      bus.instr = 32'd0; bus.flags = 3'd0;

      //         instr         flags   f  m  pc imm busy dmem alu wb
      tbl[0]  = '{32'h2000F555, 3'b000, 2, 1, 0, 1, 5,  0,  1, 0};
      tbl[1]  = '{32'h40000010, 3'b000, 1, 3, 0, 1, 7,  3,  0, 1};
      tbl[2]  = '{32'hA0000000, 3'b001, 1, 1, 1, 2, 3,  0,  0, 0};
      tbl[3]  = '{32'hA0000000, 3'b000, 1, 1, 0, 2, 3,  0,  0, 0};
      tbl[4]  = '{32'h60000004, 3'b000, 1, 2, 0, 1, 5,  2,  0, 0};
      tbl[5]  = '{32'h00000000, 3'b111, 1, 1, 0, 0, 4,  0,  0, 0};
      tbl[6]  = '{32'hC0000000, 3'b000, 1, 1, 2, 0, 3,  0,  0, 0};
      tbl[7]  = '{32'h80000000, 3'b000, 3, 1, 1, 2, 5,  0,  0, 0};
      tbl[8]  = '{32'hA4000000, 3'b001, 1, 1, 0, 2, 3,  0,  0, 0};
      tbl[9]  = '{32'hB0000000, 3'b100, 1, 1, 1, 2, 3,  0,  0, 0};
      tbl[10] = '{32'hB4000000, 3'b111, 1, 1, 0, 2, 3,  0,  0, 0};
      tbl[11] = '{32'h00000000, 3'b000, 16, 1, 0, 0, 19, 0,  0, 0};
      tbl[12] = '{32'h60000000, 3'b000, 1, 16, 0, 1, 19, 16, 0, 0};
      tbl[13] = '{32'hA8000000, 3'b010, 1, 1, 1, 2, 3,  0,  0, 0};

      // reset state
      do_reset();
      #1;
      chk("reset_outputs", outs(), 0);

      // directed table
      pulse_start();
      foreach (tbl[i]) begin
         run_instr(tbl[i].instr, tbl[i].flags, tbl[i].f_lat, tbl[i].m_lat, o);
         chk($sformatf("tbl%0d.pc_en", i),  o.n_pc,        1);
         chk($sformatf("tbl%0d.pc_src", i), o.pc_src,      tbl[i].pc_src);
         chk($sformatf("tbl%0d.imm", i),    o.imm_dec,     tbl[i].imm);
         chk($sformatf("tbl%0d.busy", i),   o.busy_cyc,    tbl[i].busy);
         chk($sformatf("tbl%0d.dmem", i),   o.dmem_cyc,    tbl[i].dmem);
         chk($sformatf("tbl%0d.alu", i),    o.alu_at_flag, tbl[i].alu);
         chk($sformatf("tbl%0d.wb", i),     o.wb_at_reg,   tbl[i].wb);
      end

      // random instruction stream against the model
      do_reset();
      pulse_start();
      for (int i = 0; i < 40; i++) begin
         ins = {3'($urandom_range(0, 6)), 29'($urandom)};
         fl  = 3'($urandom);
         fa  = $urandom_range(1, 8);
         ma  = $urandom_range(1, 8);
         run_instr(ins, fl, fa, ma, o);
         e = model(ins, fl, fa, ma);
         cmp_obs($sformatf("rnd%0d", i), o, e);
      end

      // halt instruction, then a start pulse that must be ignored
      ins = 32'hE0001234;
      run_instr(ins, 3'b000, 2, 1, o);
      cmp_obs("halt", o, model(ins, 3'b000, 2, 1));
      pulse_start();
      repeat (3) @(negedge clk);
      bus.start = 1'b0;
      #1;
      chk("halt_after_start.halted", bus.halted, 1);
      chk("halt_after_start.busy",   bus.busy,   0);
      chk("halt_after_start.req",    bus.imem_req, 0);

      // fetch timeout
      do_reset();
      pulse_start();
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         bus.start = 1'b0; bus.imem_ack = 1'b0;
         #1;
         if (bus.imem_req) cnt++;
         if (bus.halted) break;
      end
      chk("timeout.req_cycles", cnt, 16);
      chk("timeout.imem_req", bus.imem_req, 0);
      chk("timeout.err",      bus.err,      1);
      chk("timeout.halted",   bus.halted,   1);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bus.start = (k == 1);
         #1;
         if (bus.busy || !bus.halted || !bus.err) bad++;
      end
      chk("timeout.stays_halted", bad, 0);

      // reset asserted mid-MEM, ack arrives after release
      do_reset();
      pulse_start();
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         bus.start = 1'b0; bus.dmem_ack = 1'b0;
         bus.imem_ack = bus.imem_req;
         if (bus.imem_req) bus.instr = 32'h40000000;
         #1;
         if (bus.dmem_req) begin cnt = 1; break; end
      end
      chk("rstmem.reached_mem", cnt, 1);
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      rst = 1'b0;
      #1;
      chk("rstmem.outputs_in_reset", outs(), 0);
      @(negedge clk);
      rst = 1'b1;
      bus.dmem_ack = 1'b1;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (outs() != 16'd0) bad++;
         @(negedge clk);
      end
      bus.dmem_ack = 1'b0;
      chk("rstmem.late_ack_ignored", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, meaning the maximum cycles a memory request waits for an ack (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, a one-cycle pulse that leaves IDLE.
REQ-005 SHALL have port instr, input, 32, the instruction register contents.
REQ-006 SHALL have port flags, input, 3, {sign, carry, zero} from the ALU flag register.
REQ-007 SHALL have ports imem_req (output, 1) and imem_ack (input, 1), the instruction fetch handshake.
REQ-008 SHALL have ports dmem_req (output, 1), dmem_we (output, 1) and dmem_ack (input, 1), the data memory handshake.
REQ-009 SHALL have outputs ir_en, pc_en, reg_we, flag_we, alu_src and wb_sel (1 bit each), the datapath enables and selects.
REQ-010 SHALL have outputs pc_src (2 bits: 00 pc+4, 01 pc+imm, 10 register) and imm_sel (2 bits: 00 none, 01 sign-extend 16, 10 sign-extend 26).
REQ-011 SHALL have outputs busy, halted and err (1 bit each), the status flags.

Function
REQ-012 SHALL decode instr[31:29] as follows: 000 R-ALU, 001 I-ALU, 010 load, 011 store, 100 branch, 101 conditional branch, 110 branch-register, 111 halt.
REQ-013 SHALL implement the states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT, all registered.
REQ-014 SHALL make the IDLE->FETCH transition on start; start SHALL be ignored in every other state.
REQ-015 SHALL hold imem_req high in FETCH until imem_ack is sampled high, then pulse ir_en for one cycle and go to DECODE; an ack in the same cycle as the request is legal.
REQ-016 SHALL always go DECODE->EXEC; imm_sel SHALL be 01 for I-ALU, load and store, 10 for both branch classes, and 00 otherwise; imm_sel SHALL be held from DECODE through WB.
REQ-017 SHALL handle EXEC by class: R-ALU and I-ALU go to WB with flag_we high for one cycle and alu_src high only for I-ALU; load and store go to MEM.
REQ-018 SHALL handle branches in EXEC: pc_en pulses with pc_src 01 (branch), or 10 (branch-register), then the controller returns to FETCH; halt goes to HALT.
REQ-019 SHALL test the conditional branch with instr[28:26]: 000 z, 001 !z, 010 c, 011 !c, 100 s. When the condition is true, pc_src is 01. When it is false or the code is 101..111, pc_src is 00. pc_en pulses in both cases.
REQ-020 SHALL hold dmem_req high in MEM until dmem_ack, with dmem_we high for store; on ack a load goes to WB and a store pulses pc_en (pc_src 00) and returns to FETCH.
REQ-021 SHALL pulse reg_we and pc_en (pc_src 00) for one cycle in WB, with wb_sel high for load only, then go to FETCH.
REQ-022 SHALL keep pc_en, ir_en, reg_we and flag_we as one-cycle pulses, never high together except reg_we with pc_en in WB.
REQ-023 SHALL count the cycles a request is outstanding; when the count reaches ACK_TIMEOUT without an ack, the controller drops the request, sets err and goes to HALT.
REQ-024 SHALL make HALT absorbing until reset, with halted high and all enables and requests low.
REQ-025 SHALL drive busy high in every state except IDLE and HALT.

Reset
REQ-026 SHALL, while rst is low, force the state to IDLE immediately and set every output and counter to 0, including err, halted, imm_sel and pc_src.
REQ-027 SHALL drop any pending request immediately when reset is asserted mid-handshake, and SHALL ignore a late ack after reset is released.

Configuration
REQ-028 SHALL, when PERF_CNT_EN is defined, add 32-bit outputs retired (counts pc_en pulses) and cycles (counts cycles with busy high); both wrap from 0xFFFFFFFF to 0, are cleared by reset, and freeze in HALT.
REQ-029 SHALL, when PERF_CNT_EN is undefined, omit both ports and both counters entirely.

Verification
REQ-030 SHALL cover the I-ALU case: start, imem_ack after 2 cycles, instr 0x2000F555 -> imm_sel=01, alu_src=1, flag_we pulse, then reg_we+pc_en pulse, pc_src=00, back in FETCH.
REQ-031 SHALL cover the load case: instr class 010, dmem_ack after 3 cycles -> dmem_req high for exactly 3 cycles, dmem_we=0, wb_sel=1 on the reg_we pulse.
REQ-032 SHALL cover conditional branches: class 101, code 000, flags=001 -> pc_src=01, imm_sel=10; the same with flags=000 -> pc_src=00.
REQ-033 SHALL cover timeout: FETCH with imem_ack held low -> after 16 cycles imem_req=0, err=1, halted=1, and busy stays 0 from then on.
REQ-034 SHALL cover reset mid-MEM: rst low during dmem_req, ack delivered after release -> IDLE, all outputs 0, and no reg_we.
REQ-035 SHALL cover halt: class 111 -> halted=1, and a later start pulse is ignored.
